vend_select_ctrl: RTL and testbench

Transaction controller for the digital vending machine. It accumulates coin credit, validates a product selection against price, stock and credit, and drives the 3-bit slot index and enable that feed the 3:8 dispense decoder. It also issues change and cancellation refunds. It sits directly upstream of the decoder: `dispense_sel` connects to the decoder's `in`, and `dispense_en` connects to the decoder's `en`.

---
 rtl/vend_pkg.sv | 29 ++
 rtl/vend_select_ctrl_if.sv | 32 +++
 rtl/vend_dispense_timer.sv | 36 +++
 rtl/vend_select_ctrl.sv | 147 ++++++++++++++
 tb/tb_vend_select_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vend_pkg.sv
// Shared types and helpers for the vending-machine transaction controller:
// FSM state encoding and coin-code decoding.
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CREDIT   = 2'd1,
    ST_DISPENSE = 2'd2,
    ST_CHANGE   = 2'd3
  } state_t;

  localparam logic [1:0] COIN_5   = 2'b00;
  localparam logic [1:0] COIN_10  = 2'b01;
  localparam logic [1:0] COIN_25  = 2'b10;
  localparam logic [1:0] COIN_100 = 2'b11;

  function automatic logic [7:0] coin_cents(input logic [1:0] code);
    logic [7:0] cents;
    unique case (code)
      COIN_5:   cents = 8'd5;
      COIN_10:  cents = 8'd10;
      COIN_25:  cents = 8'd25;
      COIN_100: cents = 8'd100;
      default:  cents = 8'd0;
    endcase
    return cents;
  endfunction

endpackage

// File: rtl/vend_select_ctrl_if.sv
// Front-panel / decoder bundle of the vending controller. The master side is the
// coin/selection front end; the slave side is the controller itself.
interface vend_select_ctrl_if;
  logic       coin_valid;
  logic [1:0] coin_value;
  logic       sel_valid;
  logic [2:0] sel_slot;
  logic       cancel;
  logic [7:0] slot_empty;

  logic [2:0] dispense_sel;
  logic       dispense_en;
  logic [7:0] credit;
  logic       change_valid;
  logic [7:0] change_amount;
  logic       coin_reject;
  logic       err_funds;
  logic       err_soldout;
  logic       busy;

  modport master (
    output coin_valid, coin_value, sel_valid, sel_slot, cancel, slot_empty,
    input  dispense_sel, dispense_en, credit, change_valid, change_amount,
           coin_reject, err_funds, err_soldout, busy
  );

  modport slave (
    input  coin_valid, coin_value, sel_valid, sel_slot, cancel, slot_empty,
    output dispense_sel, dispense_en, credit, change_valid, change_amount,
           coin_reject, err_funds, err_soldout, busy
  );
endinterface

// File: rtl/vend_dispense_timer.sv
// Dispense-enable timer: o_active is a registered level held for exactly
// DISPENSE_CYCLES cycles after i_start; o_done flags its final cycle.
module vend_dispense_timer #(
  parameter int unsigned DISPENSE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  output logic o_active,
  output logic o_done
);

  localparam int unsigned CW = (DISPENSE_CYCLES > 1) ? $clog2(DISPENSE_CYCLES) : 1;
  // Counts the remaining active cycles minus one, so zero marks the last one.
  localparam logic [CW-1:0] LOAD = CW'(DISPENSE_CYCLES - 1);

  logic [CW-1:0] r_count;
  logic          r_active;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count  <= '0;
      r_active <= 1'b0;
    end else if (i_start) begin
      r_count  <= LOAD;
      r_active <= 1'b1;
    end else if (r_active) begin
      if (r_count == '0) r_active <= 1'b0;
      else               r_count  <= r_count - CW'(1);
    end
  end

  assign o_active = r_active;
  assign o_done   = r_active && (r_count == '0);

endmodule

// File: rtl/vend_select_ctrl.sv
// Vending transaction controller: accumulates credit, validates selections,
// drives the dispense decoder and pays change / cancellation refunds.
module vend_select_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned PRICE           = 75,
  parameter int unsigned MAX_CREDIT      = 200,
  parameter int unsigned DISPENSE_CYCLES = 4
) (
  input logic               clk,
  input logic               rst,
  vend_select_ctrl_if.slave bus
);

  localparam logic [7:0] PRICE_C = 8'(PRICE);
  localparam logic [8:0] MAX_C   = 9'(MAX_CREDIT);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_credit, w_credit_nxt;
  logic [2:0] r_dispense_sel, w_dispense_sel_nxt;
  logic       r_change_valid, w_change_valid_nxt;
  logic [7:0] r_change_amount, w_change_amount_nxt;
  logic       r_coin_reject, w_coin_reject_nxt;
  logic       r_err_funds, w_err_funds_nxt;
  logic       r_err_soldout, w_err_soldout_nxt;
  logic       r_busy, w_busy_nxt;
  logic       w_timer_start, w_timer_active, w_timer_done;
  logic [8:0] w_coin_sum;

  vend_dispense_timer #(.DISPENSE_CYCLES(DISPENSE_CYCLES)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_timer_start),
    .o_active (w_timer_active),
    .o_done   (w_timer_done)
  );

  assign w_coin_sum = {1'b0, r_credit} + {1'b0, coin_cents(bus.coin_value)};

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch to hold it.
    w_state_nxt         = r_state;
    w_credit_nxt        = r_credit;
    w_dispense_sel_nxt  = r_dispense_sel;
    w_change_valid_nxt  = 1'b0;
    w_change_amount_nxt = 8'd0;
    w_coin_reject_nxt   = 1'b0;
    w_err_funds_nxt     = 1'b0;
    w_err_soldout_nxt   = 1'b0;
    w_timer_start       = 1'b0;

    unique case (r_state)
      ST_IDLE, ST_CREDIT: begin
        // Priority cancel > coin > selection; a lower-priority selection is dropped silently.
        if (bus.cancel) begin
          w_coin_reject_nxt = bus.coin_valid;
          if (r_state == ST_CREDIT) begin
            w_change_valid_nxt  = 1'b1;
            w_change_amount_nxt = r_credit;
            w_credit_nxt        = 8'd0;
            w_state_nxt         = ST_CHANGE;
          end
        end else if (bus.coin_valid) begin
          if (w_coin_sum <= MAX_C) begin
            w_credit_nxt = w_coin_sum[7:0];
            w_state_nxt  = ST_CREDIT;
          end else begin
            w_coin_reject_nxt = 1'b1;
          end
        end else if (bus.sel_valid) begin
          if (bus.slot_empty[bus.sel_slot]) begin
            w_err_soldout_nxt = 1'b1;
          end else if (r_credit < PRICE_C) begin
            w_err_funds_nxt = 1'b1;
          end else begin
            w_dispense_sel_nxt = bus.sel_slot;
            w_credit_nxt       = r_credit - PRICE_C;
            w_timer_start      = 1'b1;
            w_state_nxt        = ST_DISPENSE;
          end
        end
      end

      ST_DISPENSE: begin
        w_coin_reject_nxt = bus.coin_valid;
        if (w_timer_done) begin
          w_dispense_sel_nxt = 3'd0;
          if (r_credit != 8'd0) begin
            w_change_valid_nxt  = 1'b1;
            w_change_amount_nxt = r_credit;
            w_credit_nxt        = 8'd0;
            w_state_nxt         = ST_CHANGE;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end

      ST_CHANGE: begin
        w_coin_reject_nxt = bus.coin_valid;
        w_state_nxt       = ST_IDLE;
      end

      default: w_state_nxt = ST_IDLE;
    endcase

    w_busy_nxt = (w_state_nxt == ST_DISPENSE) || (w_state_nxt == ST_CHANGE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_credit        <= 8'd0;
      r_dispense_sel  <= 3'd0;
      r_change_valid  <= 1'b0;
      r_change_amount <= 8'd0;
      r_coin_reject   <= 1'b0;
      r_err_funds     <= 1'b0;
      r_err_soldout   <= 1'b0;
      r_busy          <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_credit        <= w_credit_nxt;
      r_dispense_sel  <= w_dispense_sel_nxt;
      r_change_valid  <= w_change_valid_nxt;
      r_change_amount <= w_change_amount_nxt;
      r_coin_reject   <= w_coin_reject_nxt;
      r_err_funds     <= w_err_funds_nxt;
      r_err_soldout   <= w_err_soldout_nxt;
      r_busy          <= w_busy_nxt;
    end
  end

  assign bus.dispense_sel  = r_dispense_sel;
  assign bus.dispense_en   = w_timer_active;
  assign bus.credit        = r_credit;
  assign bus.change_valid  = r_change_valid;
  assign bus.change_amount = r_change_amount;
  assign bus.coin_reject   = r_coin_reject;
  assign bus.err_funds     = r_err_funds;
  assign bus.err_soldout   = r_err_soldout;
  assign bus.busy          = r_busy;

endmodule

// File: tb/tb_vend_select_ctrl.sv
// Self-checking bench for vend_select_ctrl: directed vector table, an async
// reset-during-dispense sequence and randomized traffic against a cycle model.
module tb_vend_select_ctrl;

  localparam int PRICE    = 75;
  localparam int MAXC     = 200;
  localparam int DCYC     = 4;
  localparam int N_RANDOM = 600;

  typedef struct packed {
    logic       coin_valid;
    logic [1:0] coin_value;
    logic       sel_valid;
    logic [2:0] sel_slot;
    logic       cancel;
    logic [7:0] slot_empty;
  } in_t;

  typedef struct packed {
    logic [7:0] credit;
    logic       en;
    logic [2:0] sel;
    logic       busy;
    logic       chg_v;
    logic [7:0] chg_amt;
    logic       rej;
    logic       funds;
    logic       sold;
  } out_t;

  typedef struct {
    in_t  stim;
    out_t want;
  } vec_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;
  vec_t vecs[$];

  vend_select_ctrl_if bus ();

  vend_select_ctrl #(
    .PRICE           (PRICE),
    .MAX_CREDIT      (MAXC),
    .DISPENSE_CYCLES (DCYC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic in_t i_idle();
    in_t x;
    x = '0;
    return x;
  endfunction

  function automatic in_t i_coin(input int code);
    in_t x;
    x = '0;
    x.coin_valid = 1'b1;
    x.coin_value = 2'(code);
    return x;
  endfunction

  function automatic in_t i_sel(input int slot, input int empty);
    in_t x;
    x = '0;
    x.sel_valid  = 1'b1;
    x.sel_slot   = 3'(slot);
    x.slot_empty = 8'(empty);
    return x;
  endfunction

  function automatic in_t i_cancel();
    in_t x;
    x = '0;
    x.cancel = 1'b1;
    return x;
  endfunction

  function automatic out_t ex(input int credit, input bit en, input int sel, input bit busy,
                              input bit chg, input int amt, input bit rej, input bit fnd,
                              input bit sld);
    out_t o;
    o.credit  = 8'(credit);
    o.en      = en;
    o.sel     = 3'(sel);
    o.busy    = busy;
    o.chg_v   = chg;
    o.chg_amt = 8'(amt);
    o.rej     = rej;
    o.funds   = fnd;
    o.sold    = sld;
    return o;
  endfunction

  task automatic add(input in_t i, input out_t e);
    vec_t v;
    v.stim = i;
    v.want = e;
    vecs.push_back(v);
  endtask

  function automatic out_t read_dut();
    out_t o;
    o.credit  = bus.credit;
    o.en      = bus.dispense_en;
    o.sel     = bus.dispense_sel;
    o.busy    = bus.busy;
    o.chg_v   = bus.change_valid;
    o.chg_amt = bus.change_amount;
    o.rej     = bus.coin_reject;
    o.funds   = bus.err_funds;
    o.sold    = bus.err_soldout;
    return o;
  endfunction

  task automatic check(input string name, input out_t act, input out_t req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got credit=%0d en=%b sel=%0d busy=%b chg=%b/%0d rej=%b funds=%b sold=%b, want credit=%0d en=%b sel=%0d busy=%b chg=%b/%0d rej=%b funds=%b sold=%b",
               name, act.credit, act.en, act.sel, act.busy, act.chg_v, act.chg_amt, act.rej,
               act.funds, act.sold, req.credit, req.en, req.sel, req.busy, req.chg_v,
               req.chg_amt, req.rej, req.funds, req.sold);
    end
  endtask

  task automatic drive(input in_t i);
    bus.coin_valid = i.coin_valid;
    bus.coin_value = i.coin_value;
    bus.sel_valid  = i.sel_valid;
    bus.sel_slot   = i.sel_slot;
    bus.cancel     = i.cancel;
    bus.slot_empty = i.slot_empty;
  endtask

  // Apply inputs for one edge, then sample 1 ns after it.
  task automatic step(input in_t i, output out_t act);
    drive(i);
    @(posedge clk);
    #1;
    act = read_dut();
  endtask

  task automatic do_reset();
    drive(i_idle());
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- reference model ----------------
  // Tracks credit in cents, how many dispense cycles remain, and whether the
  // current cycle is the one-cycle change payout.
  int m_credit;
  int m_disp_left;
  int m_slot;
  bit m_in_change;
  int cents_tbl[4] = '{5, 10, 25, 100};

  task automatic model_reset();
    m_credit    = 0;
    m_disp_left = 0;
    m_slot      = 0;
    m_in_change = 1'b0;
  endtask

  task automatic model_edge(input in_t i, output out_t e);
    bit busy_now;
    int v;
    busy_now = (m_disp_left > 0) || m_in_change;
    e        = '0;
    e.rej    = i.coin_valid && (busy_now || i.cancel);
    if (m_in_change) begin
      m_in_change = 1'b0;
    end else if (m_disp_left > 0) begin
      m_disp_left--;
      if (m_disp_left == 0 && m_credit > 0) begin
        e.chg_v     = 1'b1;
        e.chg_amt   = 8'(m_credit);
        m_credit    = 0;
        m_in_change = 1'b1;
      end
    end else if (i.cancel) begin
      if (m_credit > 0) begin
        e.chg_v     = 1'b1;
        e.chg_amt   = 8'(m_credit);
        m_credit    = 0;
        m_in_change = 1'b1;
      end
    end else if (i.coin_valid) begin
      v = cents_tbl[i.coin_value];
      if (m_credit + v <= MAXC) m_credit += v;
      else                      e.rej = 1'b1;
    end else if (i.sel_valid) begin
      if (i.slot_empty[i.sel_slot])  e.sold = 1'b1;
      else if (m_credit < PRICE)     e.funds = 1'b1;
      else begin
        m_credit   -= PRICE;
        m_disp_left = DCYC;
        m_slot      = int'(i.sel_slot);
      end
    end
    e.en     = (m_disp_left > 0);
    e.sel    = e.en ? 3'(m_slot) : 3'd0;
    e.credit = 8'(m_credit);
    e.busy   = e.en || m_in_change;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    out_t act;
    out_t want;
    in_t  ri;
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    drive(i_idle());

    // Coins: 0=5, 1=10, 2=25, 3=100. ex(credit,en,sel,busy, chg,amt, rej,funds,sold)
    // Three quarters then slot 3: exact-price vend, no change.
    add(i_coin(2),  ex(25, 0, 0, 0, 0, 0, 0, 0, 0));
    add(i_coin(2),  ex(50, 0, 0, 0, 0, 0, 0, 0, 0));
    add(i_coin(2),  ex(75, 0, 0, 0, 0, 0, 0, 0, 0));
    add(i_sel(3, 0), ex(0, 1, 3, 1, 0, 0, 0, 0, 0));
    add(i_idle(),   ex(0, 1, 3, 1, 0, 0, 0, 0, 0));
    add(i_idle(),   ex(0, 1, 3, 1, 0, 0, 0, 0, 0));
    add(i_idle(),   ex(0, 1, 3, 1, 0, 0, 0, 0, 0));
    add(i_idle(),   ex(0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Dollar coin, slot 5, 25 cents change after the dispense window.
    add(i_coin(3),  ex(100, 0, 0, 0, 0, 0, 0, 0, 0));
    add(i_sel(5, 0), ex(25, 1, 5, 1, 0, 0, 0, 0, 0));
    add(i_idle(),   ex(25, 1, 5, 1, 0, 0, 0, 0, 0));
    add(i_idle(),   ex(25, 1, 5, 1, 0, 0, 0, 0, 0));
    add(i_idle(),   ex(25, 1, 5, 1, 0, 0, 0, 0, 0));
    add(i_idle(),   ex(0, 0, 0, 1, 1, 25, 0, 0, 0));
    add(i_idle(),   ex(0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Insufficient funds, then cancel refund.
    add(i_coin(2),  ex(25, 0, 0, 0, 0, 0, 0, 0, 0));
    add(i_sel(1, 0), ex(25, 0, 0, 0, 0, 0, 0, 1, 0));
    add(i_cancel(), ex(0, 0, 0, 1, 1, 25, 0, 0, 0));
    add(i_idle(),   ex(0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Credit ceiling exactly reached, overflow coin rejected, sold-out slot 7.
    add(i_coin(3),  ex(100, 0, 0, 0, 0, 0, 0, 0, 0));
    add(i_coin(3),  ex(200, 0, 0, 0, 0, 0, 0, 0, 0));
    add(i_coin(0),  ex(200, 0, 0, 0, 0, 0, 1, 0, 0));
    add(i_sel(7, 8'h80), ex(200, 0, 0, 0, 0, 0, 0, 0, 1));
    add(i_cancel(), ex(0, 0, 0, 1, 1, 200, 0, 0, 0));
    add(i_idle(),   ex(0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Coin+select collision at 75, then coins rejected during dispense and change.
    add(i_coin(2),  ex(25, 0, 0, 0, 0, 0, 0, 0, 0));
    add(i_coin(2),  ex(50, 0, 0, 0, 0, 0, 0, 0, 0));
    add(i_coin(2),  ex(75, 0, 0, 0, 0, 0, 0, 0, 0));
    add(in_t'(i_coin(2) | i_sel(0, 0)), ex(100, 0, 0, 0, 0, 0, 0, 0, 0));
    add(i_sel(2, 0), ex(25, 1, 2, 1, 0, 0, 0, 0, 0));
    add(i_coin(1),  ex(25, 1, 2, 1, 0, 0, 1, 0, 0));
    add(i_coin(0),  ex(25, 1, 2, 1, 0, 0, 1, 0, 0));
    add(i_idle(),   ex(25, 1, 2, 1, 0, 0, 0, 0, 0));
    add(i_idle(),   ex(0, 0, 0, 1, 1, 25, 0, 0, 0));
    add(i_coin(0),  ex(0, 0, 0, 0, 0, 0, 1, 0, 0));
    // Cancel beats coin (even in IDLE) and silently drops a selection.
    add(in_t'(i_cancel() | i_coin(1)), ex(0, 0, 0, 0, 0, 0, 1, 0, 0));
    add(i_coin(3),  ex(100, 0, 0, 0, 0, 0, 0, 0, 0));
    add(in_t'(i_cancel() | i_sel(0, 0)), ex(0, 0, 0, 1, 1, 100, 0, 0, 0));
    add(i_idle(),   ex(0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Sold-out is checked before funds.
    add(i_sel(4, 8'h10), ex(0, 0, 0, 0, 0, 0, 0, 0, 1));
    add(i_sel(4, 0), ex(0, 0, 0, 0, 0, 0, 0, 1, 0));

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", read_dut(), ex(0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;

    for (int k = 0; k < vecs.size(); k++) begin
      step(vecs[k].stim, act);
      check($sformatf("vec%0d", k), act, vecs[k].want);
    end

    // Asynchronous reset in the second dispense cycle.
    do_reset();
    step(i_coin(3), act);
    step(i_sel(6, 0), act);
    check("rst_seq_dispense1", act, ex(25, 1, 6, 1, 0, 0, 0, 0, 0));
    step(i_idle(), act);
    check("rst_seq_dispense2", act, ex(25, 1, 6, 1, 0, 0, 0, 0, 0));
    #3;
    rst = 1'b1;
    #1;
    check("rst_async_drop", read_dut(), ex(0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < DCYC + 3; k++) begin
      step(i_idle(), act);
      check($sformatf("rst_after%0d", k), act, ex(0, 0, 0, 0, 0, 0, 0, 0, 0));
    end

    // Randomized traffic against the model.
    do_reset();
    model_reset();
    for (int k = 0; k < N_RANDOM; k++) begin
      ri            = '0;
      ri.coin_valid = ($urandom_range(99) < 30);
      ri.coin_value = 2'($urandom_range(3));
      ri.sel_valid  = ($urandom_range(99) < 25);
      ri.sel_slot   = 3'($urandom_range(7));
      ri.cancel     = ($urandom_range(99) < 6);
      ri.slot_empty = 8'($urandom & $urandom & $urandom);
      step(ri, act);
      model_edge(ri, want);
      check($sformatf("rand%0d", k), act, want);
    end

    drive(i_idle());
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
